mem_line_initiator: RTL and testbench
=====================================

# mem_line_initiator

Initiator-side controller that sits between the data cache and the data port of the block-RAM main memory. It accepts one request at a time from the cache: line fill, line writeback, uncached word read, or uncached word write. It drives the memory's command, address and data signals and holds them as the memory protocol requires. For reads it reassembles the offset-tagged 32-bit beats into a 128-bit line, signals the critical word early, and returns one completion pulse per request.

## Interface
- ADDR_WIDTH, 12, line-address width of main memory; word addresses are ADDR_WIDTH+2 bits.
- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- Req_Valid  in  1  request present; accepted when Req_Valid & Req_Ready.
- Req_Op  in  2  00 fill, 01 writeback, 10 uncached read, 11 uncached write.
- Req_Address  in  ADDR_WIDTH+2  word address.
- Req_LineData  in  128  writeback line; word 0 is in [127:96].
- Req_WordData  in  32  uncached write data.
- Req_WordBE  in  4  uncached write byte enables; bit 3 maps to [31:24].
- Req_Ready  out  1  high only in IDLE.
- Rsp_Valid  out  1  one-cycle completion pulse.
- Rsp_Line  out  128  assembled fill line; valid with Rsp_Valid for fills.
- Rsp_Word  out  32  critical word (fill) or read word (uncached read).
- Rsp_CritValid  out  1  one-cycle pulse when Rsp_Word holds the requested word.
- M_Address  out  ADDR_WIDTH+2  memory word address.
- M_ReadLine, M_ReadWord  out  1  one-cycle command pulses.
- M_LineInReady, M_WordInReady  out  1  write strobes, held until M_Ready.
- M_WordInBE  out  4  byte enables for the word write.
- M_DataOut  out  128  write data; word writes use [31:0].
- M_DataIn  in  32  read beat.
- M_DataInOffset  in  2  slot of the current beat.
- M_Ready  in  1  beat or write-complete qualifier.
- Stray_Ready  out  1  sticky flag; set when M_Ready is seen in IDLE, RD_CMD or DONE; cleared only by reset.

## Operation
- All outputs are registered. Reset value of every output is 0, except Req_Ready, which is 1.
- State machine:
  - IDLE → RD_CMD on an accepted fill or uncached read.
  - IDLE → WR_WAIT on an accepted writeback or uncached write.
  - RD_CMD → RD_WAIT.
  - RD_WAIT → DONE after the last beat: 4 beats for a fill, 1 for an uncached read.
  - WR_WAIT → DONE on M_Ready.
  - DONE → IDLE.
- On accept, latch Req_Op, address, data and BE. M_Address holds the latched address from the cycle after accept through DONE, then returns to 0.
- RD_CMD: M_ReadLine (fill) or M_ReadWord (uncached read) is high for exactly that one cycle.
- RD_WAIT beat capture, on each M_Ready:
  - Write M_DataIn into Rsp_Line slot M_DataInOffset: 0 → [127:96], 1 → [95:64], 2 → [63:32], 3 → [31:0].
  - Increment the 2-bit beat counter. Counter resets to 0 on accept.
- Beat order is whatever the memory delivers (critical-word-first or sequential). Capture is placed by offset only.
- Critical word:
  - Fill: on the beat whose offset equals the latched address[1:0], load Rsp_Word and pulse Rsp_CritValid the next cycle.
  - Uncached read: the single beat loads Rsp_Word and pulses Rsp_CritValid.
- WR_WAIT:
  - M_LineInReady (writeback) or M_WordInReady (uncached write) is held high.
  - M_DataOut = latched line, or {96'b0, word}. M_WordInBE = latched BE; it is 0 for writebacks.
  - Strobe and data drop on the edge after M_Ready is sampled high.
- DONE: Rsp_Valid = 1 for one cycle. Rsp_Line and Rsp_Word keep their values until the next accept.
- Reset mid-operation: the next edge returns the FSM to IDLE and clears all strobes and pulses. The outstanding request is abandoned with no Rsp_Valid.

## Timing
- Accept at edge k: command pulse or write strobe is visible in cycle k+1.
- The memory samples the read pulse in its IDLE state. The memory is idle again before this block can issue another command, since the minimum inter-command gap is DONE + IDLE = 2 cycles.
- Last M_Ready beat sampled at edge j: Rsp_Valid high in cycle j+1, Req_Ready high in cycle j+2.
- Write: M_Ready sampled at edge j drops the strobe in cycle j+1, with Rsp_Valid in the same cycle. This keeps the memory from re-triggering on return to its IDLE.
- Back-to-back requests are accepted every (memory latency + 3) cycles at best.

## Test plan
- Fill, address 0x0006, memory returns offsets 2,3,0,1 with words 0xA2,0xA3,0xA0,0xA1 → Rsp_CritValid one cycle after the offset-2 beat with Rsp_Word=0xA2; Rsp_Line={A0,A1,A2,A3}; exactly one Rsp_Valid.
- Uncached write, address 0x0013, data 0xDEADBEEF, BE 0b0110, memory Ready after 5 cycles → M_WordInReady held 5 cycles then low on the next edge; M_DataOut[31:0]=0xDEADBEEF; Rsp_Valid one cycle.
- Writeback of line 0x00112233_44556677_8899AABB_CCDDEEFF → M_LineInReady held until M_Ready; M_DataOut equals the line throughout; M_Address constant.
- Uncached read, offset 1, beat 0x12345678 → Rsp_Word=0x12345678, Rsp_CritValid and Rsp_Valid pulses; M_ReadWord high for exactly 1 cycle.
- Reset asserted after the second fill beat → all M_* strobes 0 and Req_Ready=1 on the next cycle; no Rsp_Valid.
- M_Ready pulsed while idle → Stray_Ready=1 and stays 1 through a later complete fill until reset.

Source files
------------

// File: rtl/mem_line_initiator_if.sv
// Cache-side request/response and memory-side command/data bundle for mem_line_initiator.
// The slave modport is the initiator's view; the master modport is the cache+memory environment.
interface mem_line_initiator_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  Req_Valid;
  logic [1:0]            Req_Op;
  logic [ADDR_WIDTH+1:0] Req_Address;
  logic [127:0]          Req_LineData;
  logic [31:0]           Req_WordData;
  logic [3:0]            Req_WordBE;
  logic                  Req_Ready;
  logic                  Rsp_Valid;
  logic [127:0]          Rsp_Line;
  logic [31:0]           Rsp_Word;
  logic                  Rsp_CritValid;
  logic [ADDR_WIDTH+1:0] M_Address;
  logic                  M_ReadLine;
  logic                  M_ReadWord;
  logic                  M_LineInReady;
  logic                  M_WordInReady;
  logic [3:0]            M_WordInBE;
  logic [127:0]          M_DataOut;
  logic [31:0]           M_DataIn;
  logic [1:0]            M_DataInOffset;
  logic                  M_Ready;
  logic                  Stray_Ready;

  modport slave (
    input  Req_Valid, Req_Op, Req_Address, Req_LineData, Req_WordData, Req_WordBE,
    input  M_DataIn, M_DataInOffset, M_Ready,
    output Req_Ready, Rsp_Valid, Rsp_Line, Rsp_Word, Rsp_CritValid,
    output M_Address, M_ReadLine, M_ReadWord, M_LineInReady, M_WordInReady,
    output M_WordInBE, M_DataOut, Stray_Ready
  );

  modport master (
    output Req_Valid, Req_Op, Req_Address, Req_LineData, Req_WordData, Req_WordBE,
    output M_DataIn, M_DataInOffset, M_Ready,
    input  Req_Ready, Rsp_Valid, Rsp_Line, Rsp_Word, Rsp_CritValid,
    input  M_Address, M_ReadLine, M_ReadWord, M_LineInReady, M_WordInReady,
    input  M_WordInBE, M_DataOut, Stray_Ready
  );
endinterface

// File: rtl/mem_line_initiator.sv
// One-at-a-time cache-to-BRAM initiator: line fill/writeback, uncached word read/write.
// Command one cycle after accept, response one cycle after the last beat; Req_Ready is low while busy.
module mem_line_initiator #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_line_initiator_if.slave  bus
);
  localparam int WA = ADDR_WIDTH + 2;
  localparam logic [1:0] OP_FILL = 2'b00;
  localparam logic [1:0] OP_WB   = 2'b01;
  localparam logic [1:0] OP_URD  = 2'b10;
  localparam logic [1:0] OP_UWR  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_RD_CMD, S_RD_WAIT, S_WR_WAIT, S_DONE} state_t;

  state_t         r_state, w_state;
  logic [1:0]     r_op, w_op;
  logic [1:0]     r_beat_cnt, w_beat_cnt;
  logic           r_req_ready, w_req_ready;
  logic           r_rsp_valid, w_rsp_valid;
  logic           r_crit_valid, w_crit_valid;
  logic [127:0]   r_rsp_line, w_rsp_line;
  logic [31:0]    r_rsp_word, w_rsp_word;
  logic [WA-1:0]  r_m_addr, w_m_addr;
  logic           r_rd_line, w_rd_line;
  logic           r_rd_word, w_rd_word;
  logic           r_line_in_rdy, w_line_in_rdy;
  logic           r_word_in_rdy, w_word_in_rdy;
  logic [3:0]     r_be_out, w_be_out;
  logic [127:0]   r_data_out, w_data_out;
  logic           r_stray, w_stray;

  always_comb begin
    w_state       = r_state;
    w_op          = r_op;
    w_beat_cnt    = r_beat_cnt;
    w_req_ready   = r_req_ready;
    w_rsp_valid   = 1'b0;
    w_crit_valid  = 1'b0;
    w_rsp_line    = r_rsp_line;
    w_rsp_word    = r_rsp_word;
    w_m_addr      = r_m_addr;
    w_rd_line     = 1'b0;
    w_rd_word     = 1'b0;
    w_line_in_rdy = r_line_in_rdy;
    w_word_in_rdy = r_word_in_rdy;
    w_be_out      = r_be_out;
    w_data_out    = r_data_out;
    w_stray       = r_stray;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.M_Ready) w_stray = 1'b1;
        if (bus.Req_Valid && r_req_ready) begin
          w_op        = bus.Req_Op;
          w_m_addr    = bus.Req_Address;
          w_beat_cnt  = 2'd0;
          w_req_ready = 1'b0;
          case (bus.Req_Op)
            OP_FILL: begin w_state = S_RD_CMD; w_rd_line = 1'b1; end
            OP_URD:  begin w_state = S_RD_CMD; w_rd_word = 1'b1; end
            OP_WB: begin
              w_state       = S_WR_WAIT;
              w_line_in_rdy = 1'b1;
              w_data_out    = bus.Req_LineData;
              w_be_out      = 4'b0000;
            end
            default: begin
              w_state       = S_WR_WAIT;
              w_word_in_rdy = 1'b1;
              w_data_out    = {96'b0, bus.Req_WordData};
              w_be_out      = bus.Req_WordBE;
            end
          endcase
        end
      end
      S_RD_CMD: begin
        if (bus.M_Ready) w_stray = 1'b1;
        w_state = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (bus.M_Ready) begin
          // Beats are placed by their offset tag, so delivery order does not matter.
          w_rsp_line[{~bus.M_DataInOffset, 5'b00000} +: 32] = bus.M_DataIn;
          w_beat_cnt = r_beat_cnt + 2'd1;
          if (r_op == OP_URD || bus.M_DataInOffset == r_m_addr[1:0]) begin
            w_rsp_word   = bus.M_DataIn;
            w_crit_valid = 1'b1;
          end
          if (r_op == OP_URD || r_beat_cnt == 2'd3) begin
            w_state     = S_DONE;
            w_rsp_valid = 1'b1;
          end
        end
      end
      S_WR_WAIT: begin
        if (bus.M_Ready) begin
          // Strobe drops with the response so the memory cannot re-trigger on return to idle.
          w_line_in_rdy = 1'b0;
          w_word_in_rdy = 1'b0;
          w_data_out    = '0;
          w_be_out      = 4'b0000;
          w_rsp_valid   = 1'b1;
          w_state       = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.M_Ready) w_stray = 1'b1;
        w_state     = S_IDLE;
        w_req_ready = 1'b1;
        w_m_addr    = '0;
      end
      default: begin
        w_state     = S_IDLE;
        w_req_ready = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_op          <= 2'b00;
      r_beat_cnt    <= 2'd0;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_crit_valid  <= 1'b0;
      r_rsp_line    <= '0;
      r_rsp_word    <= '0;
      r_m_addr      <= '0;
      r_rd_line     <= 1'b0;
      r_rd_word     <= 1'b0;
      r_line_in_rdy <= 1'b0;
      r_word_in_rdy <= 1'b0;
      r_be_out      <= 4'b0000;
      r_data_out    <= '0;
      r_stray       <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_op          <= w_op;
      r_beat_cnt    <= w_beat_cnt;
      r_req_ready   <= w_req_ready;
      r_rsp_valid   <= w_rsp_valid;
      r_crit_valid  <= w_crit_valid;
      r_rsp_line    <= w_rsp_line;
      r_rsp_word    <= w_rsp_word;
      r_m_addr      <= w_m_addr;
      r_rd_line     <= w_rd_line;
      r_rd_word     <= w_rd_word;
      r_line_in_rdy <= w_line_in_rdy;
      r_word_in_rdy <= w_word_in_rdy;
      r_be_out      <= w_be_out;
      r_data_out    <= w_data_out;
      r_stray       <= w_stray;
    end
  end

  assign bus.Req_Ready     = r_req_ready;
  assign bus.Rsp_Valid     = r_rsp_valid;
  assign bus.Rsp_Line      = r_rsp_line;
  assign bus.Rsp_Word      = r_rsp_word;
  assign bus.Rsp_CritValid = r_crit_valid;
  assign bus.M_Address     = r_m_addr;
  assign bus.M_ReadLine    = r_rd_line;
  assign bus.M_ReadWord    = r_rd_word;
  assign bus.M_LineInReady = r_line_in_rdy;
  assign bus.M_WordInReady = r_word_in_rdy;
  assign bus.M_WordInBE    = r_be_out;
  assign bus.M_DataOut     = r_data_out;
  assign bus.Stray_Ready   = r_stray;
endmodule

// File: tb/tb_mem_line_initiator.sv
// Scoreboard bench for mem_line_initiator: randomized cache requests against a word-array
// reference model, with a behavioural BRAM responder and decoupled response monitors.
module tb_mem_line_initiator;
  localparam int AW = 12;
  localparam int WA = AW + 2;
  localparam logic [1:0] OP_FILL = 2'b00;
  localparam logic [1:0] OP_WB   = 2'b01;
  localparam logic [1:0] OP_URD  = 2'b10;
  localparam logic [1:0] OP_UWR  = 2'b11;

  typedef struct {
    logic [1:0]   op;
    logic [127:0] line;
    logic [31:0]  word;
  } rsp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  rsp_t        rsp_q[$];
  int          done_cyc_q[$];
  logic [31:0] crit_q[$];
  int          crit_cyc_q[$];

  int order_mode = 0;
  int rd_lat_fix = 0;
  int wr_wait_fix = 0;
  int beat_cnt = 0;
  int stray_req = 0;
  int stray_done = 0;

  mem_line_initiator_if #(.ADDR_WIDTH(AW)) bus ();
  mem_line_initiator #(.ADDR_WIDTH(AW)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory side: serves read commands from mem[] and commits writes into it.
  task automatic serve_read();
    logic          is_line;
    logic [WA-1:0] a;
    logic [1:0]    off;
    int            lat, nb, mode;
    is_line  = bus.M_ReadLine;
    a        = bus.M_Address;
    beat_cnt = 0;
    lat  = (rd_lat_fix > 0) ? rd_lat_fix : int'($urandom_range(4, 1));
    mode = (order_mode > 0) ? order_mode : int'($urandom_range(2, 1));
    nb   = is_line ? 4 : 1;
    @(posedge clock); #1;
    if (reset) return;
    check("rd_cmd_one_cycle", {126'b0, bus.M_ReadLine, bus.M_ReadWord}, 128'b0);
    for (int i = 1; i < lat; i++) begin
      @(posedge clock); #1;
      if (reset) return;
    end
    for (int i = 0; i < nb; i++) begin
      off = is_line ? ((mode == 1) ? a[1:0] + 2'(i) : 2'(i)) : a[1:0];
      bus.M_DataIn       = is_line ? mem[{a[7:2], off}] : mem[a[7:0]];
      bus.M_DataInOffset = off;
      bus.M_Ready        = 1'b1;
      beat_cnt++;
      if (!is_line || off == a[1:0]) crit_cyc_q.push_back(cyc + 1);
      if (i == nb - 1) done_cyc_q.push_back(cyc + 1);
      @(posedge clock); #1;
      bus.M_Ready = 1'b0;
      if (reset) return;
      if (i < nb - 1 && $urandom_range(2, 0) == 0) begin
        @(posedge clock); #1;
        if (reset) return;
      end
    end
  endtask

  task automatic serve_write();
    logic          is_line;
    logic [WA-1:0] a;
    logic [127:0]  d0;
    logic [3:0]    be0;
    int            n, hi;
    bit            stable;
    is_line = bus.M_LineInReady;
    a       = bus.M_Address;
    d0      = bus.M_DataOut;
    be0     = bus.M_WordInBE;
    n       = (wr_wait_fix > 0) ? wr_wait_fix : int'($urandom_range(6, 1));
    hi      = 0;
    stable  = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clock); #1;
        if (reset) return;
      end
      if (bus.M_LineInReady || bus.M_WordInReady) hi++;
      if (bus.M_DataOut !== d0 || bus.M_Address !== a) stable = 1'b0;
    end
    bus.M_Ready = 1'b1;
    done_cyc_q.push_back(cyc + 1);
    if (is_line) begin
      for (int k = 0; k < 4; k++) mem[{a[7:2], 2'(k)}] = d0[127 - 32*k -: 32];
    end else begin
      for (int b = 0; b < 4; b++) if (be0[b]) mem[a[7:0]][8*b +: 8] = d0[8*b +: 8];
    end
    @(posedge clock); #1;
    bus.M_Ready = 1'b0;
    check("wr_strobe_cycles", hi, n);
    check("wr_data_addr_stable", {127'b0, stable}, 128'd1);
    check("wr_strobe_drop", {126'b0, bus.M_LineInReady, bus.M_WordInReady}, 128'b0);
    if (is_line) check("wb_be_zero", {124'b0, be0}, 128'b0);
    else         check("uw_upper_zero", {32'b0, d0[127:32]}, 128'b0);
  endtask

  initial begin
    bus.M_Ready        = 1'b0;
    bus.M_DataIn       = '0;
    bus.M_DataInOffset = '0;
    forever begin
      @(posedge clock); #1;
      bus.M_Ready = 1'b0;
      if (reset) continue;
      if (bus.M_ReadLine || bus.M_ReadWord) serve_read();
      else if (bus.M_LineInReady || bus.M_WordInReady) serve_write();
      else if (stray_req != stray_done && bus.Req_Ready) begin
        bus.M_Ready = 1'b1;
        stray_done++;
      end
    end
  end

  // Monitors: pop expectations whenever the DUT presents a pulse.
  rsp_t        mon_r;
  int          mon_c;
  logic [31:0] mon_w;
  always @(negedge clock) begin
    if (!reset && bus.Rsp_Valid) begin
      if (rsp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_rsp_valid: got Rsp_Valid=1 at cycle %0d, expected none", cyc);
      end else begin
        mon_r = rsp_q.pop_front();
        mon_c = (done_cyc_q.size() > 0) ? done_cyc_q.pop_front() : -1;
        check("rsp_valid_cycle", cyc, mon_c);
        check("req_ready_low_in_done", {127'b0, bus.Req_Ready}, 128'b0);
        if (mon_r.op == OP_FILL) begin
          check("fill_line", bus.Rsp_Line, mon_r.line);
          check("fill_word", {96'b0, bus.Rsp_Word}, {96'b0, mon_r.word});
        end else if (mon_r.op == OP_URD) begin
          check("urd_word", {96'b0, bus.Rsp_Word}, {96'b0, mon_r.word});
        end
      end
    end
    if (!reset && bus.Rsp_CritValid) begin
      if (crit_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_crit_valid: got Rsp_CritValid=1 at cycle %0d, expected none", cyc);
      end else begin
        mon_w = crit_q.pop_front();
        mon_c = (crit_cyc_q.size() > 0) ? crit_cyc_q.pop_front() : -1;
        check("crit_cycle", cyc, mon_c);
        check("crit_word", {96'b0, bus.Rsp_Word}, {96'b0, mon_w});
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [WA-1:0] a, input logic [127:0] line,
                       input logic [31:0] w, input logic [3:0] be, input bit want_rsp);
    rsp_t       r;
    logic [7:0] base;
    int         t;
    base = {a[7:2], 2'b00};
    t    = 0;
    @(posedge clock); #2;
    while (bus.Req_Ready !== 1'b1 && t < 300) begin
      @(posedge clock); #2;
      t++;
    end
    if (t >= 300) begin
      n_cmp++; n_fail++;
      $display("FAIL req_ready_timeout: got Req_Ready=0 for %0d cycles, expected 1", t);
      return;
    end
    r.op = op; r.line = '0; r.word = '0;
    case (op)
      OP_FILL: begin
        r.line = {ref_mem[base], ref_mem[base + 8'd1], ref_mem[base + 8'd2], ref_mem[base + 8'd3]};
        r.word = ref_mem[a[7:0]];
        crit_q.push_back(r.word);
      end
      OP_URD: begin
        r.word = ref_mem[a[7:0]];
        crit_q.push_back(r.word);
      end
      OP_WB: for (int k = 0; k < 4; k++) ref_mem[base + 8'(k)] = line[127 - 32*k -: 32];
      default: for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a[7:0]][8*b +: 8] = w[8*b +: 8];
    endcase
    if (want_rsp) rsp_q.push_back(r);
    bus.Req_Valid    = 1'b1;
    bus.Req_Op       = op;
    bus.Req_Address  = a;
    bus.Req_LineData = line;
    bus.Req_WordData = w;
    bus.Req_WordBE   = be;
    @(posedge clock); #2;
    bus.Req_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(posedge clock); #2;
    while ((rsp_q.size() != 0 || bus.Req_Ready !== 1'b1) && t < 300) begin
      @(posedge clock); #2;
      t++;
    end
    if (t >= 300) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout: got %0d pending responses after %0d cycles, expected 0", rsp_q.size(), t);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req_ready"}, {127'b0, bus.Req_Ready}, 128'd1);
    check({tag, "_rsp_pulses"}, {126'b0, bus.Rsp_Valid, bus.Rsp_CritValid}, 128'b0);
    check({tag, "_m_strobes"}, {124'b0, bus.M_ReadLine, bus.M_ReadWord, bus.M_LineInReady, bus.M_WordInReady}, 128'b0);
    check({tag, "_m_address"}, {114'b0, bus.M_Address}, 128'b0);
  endtask

  initial begin
    logic [1:0]    op;
    logic [WA-1:0] a;
    logic [127:0]  line;
    logic [31:0]   w;
    logic [3:0]    be;
    int            t;
    bus.Req_Valid = 1'b0; bus.Req_Op = '0; bus.Req_Address = '0;
    bus.Req_LineData = '0; bus.Req_WordData = '0; bus.Req_WordBE = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[4] = 32'hA0; mem[5] = 32'hA1; mem[6] = 32'hA2; mem[7] = 32'hA3;
    mem[8'h21] = 32'h12345678;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    check_quiet("reset");
    check("reset_data_out", bus.M_DataOut, 128'b0);
    check("reset_be", {124'b0, bus.M_WordInBE}, 128'b0);
    check("reset_rsp_line", bus.Rsp_Line, 128'b0);
    check("reset_rsp_word", {96'b0, bus.Rsp_Word}, 128'b0);
    check("reset_stray", {127'b0, bus.Stray_Ready}, 128'b0);
    reset = 1'b0;

    // Directed: critical-word-first fill at word 6, beats arrive 2,3,0,1.
    order_mode = 1; rd_lat_fix = 2;
    issue(OP_FILL, 14'h0006, '0, '0, '0, 1'b1);
    wait_idle();
    check("addr_back_to_zero", {114'b0, bus.M_Address}, 128'b0);
    order_mode = 0; rd_lat_fix = 0;

    // Directed: uncached write held for 5 cycles, then read back to confirm the byte merge.
    wr_wait_fix = 5;
    issue(OP_UWR, 14'h0013, '0, 32'hDEADBEEF, 4'b0110, 1'b1);
    wait_idle();
    wr_wait_fix = 3;
    issue(OP_WB, 14'h0040, 128'h00112233_44556677_8899AABB_CCDDEEFF, '0, '0, 1'b1);
    wait_idle();
    wr_wait_fix = 0;
    issue(OP_URD, 14'h0013, '0, '0, '0, 1'b1);
    issue(OP_FILL, 14'h0042, '0, '0, '0, 1'b1);
    issue(OP_URD, 14'h0021, '0, '0, '0, 1'b1);
    wait_idle();

    for (int n = 0; n < 150; n++) begin
      op   = 2'($urandom_range(3, 0));
      a    = 14'($urandom_range(255, 0));
      line = {$urandom, $urandom, $urandom, $urandom};
      w    = $urandom;
      be   = 4'($urandom_range(15, 0));
      issue(op, a, line, w, be, 1'b1);
    end
    wait_idle();
    check("stray_clear_after_traffic", {127'b0, bus.Stray_Ready}, 128'b0);

    // M_Ready while idle must set the sticky flag, which survives a full fill.
    stray_req++;
    t = 0;
    while (stray_done != stray_req && t < 50) begin
      @(posedge clock); #2;
      t++;
    end
    @(posedge clock); #2;
    check("stray_set", {127'b0, bus.Stray_Ready}, 128'd1);
    issue(OP_FILL, 14'h0085, '0, '0, '0, 1'b1);
    wait_idle();
    check("stray_sticky", {127'b0, bus.Stray_Ready}, 128'd1);

    // Reset after the second fill beat abandons the request without a response.
    order_mode = 1; rd_lat_fix = 1;
    issue(OP_FILL, 14'h0031, '0, '0, '0, 1'b0);
    t = 0;
    while (beat_cnt < 2 && t < 50) begin
      @(posedge clock); #2;
      t++;
    end
    check("reset_test_beats_seen", {127'b0, beat_cnt >= 2}, 128'd1);
    @(posedge clock); #2;
    reset = 1'b1;
    @(posedge clock); #2;
    reset = 1'b0;
    check_quiet("midreset");
    check("midreset_stray", {127'b0, bus.Stray_Ready}, 128'b0);
    order_mode = 0; rd_lat_fix = 0;

    for (int n = 0; n < 12; n++) begin
      op   = 2'($urandom_range(3, 0));
      a    = 14'($urandom_range(255, 0));
      line = {$urandom, $urandom, $urandom, $urandom};
      issue(op, a, line, $urandom, 4'($urandom_range(15, 0)), 1'b1);
    end
    wait_idle();
    repeat (4) @(posedge clock);
    #2;
    check("rsp_queue_drained", rsp_q.size(), 0);
    check("crit_queue_drained", crit_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
